ex_alu_seq: RTL and testbench

- Parametrised, multi-cycle successor to the combinational EX-stage ALU.
- Executes the same 5-bit arithmetic/logic opcode set on WIDTH-bit operands.
- Single-cycle ops: AND/OR/NOT/ADD/SUB/SHL/SHR/CMP. MULT uses an iterative shift-add unit; DIV uses an iterative restoring divider.
- Sits between ID/EX operand latch and EX/MEM register, with valid/ready handshakes on input and output so the pipeline stalls on long ops.

---
 rtl/ex_alu_seq_if.sv | 28 ++
 rtl/ex_alu_seq.sv | 176 +++++++++++++++++
 tb/tb_ex_alu_seq.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ex_alu_seq_if.sv
// Operand/result handshake bundle for the sequential EX-stage ALU.
// The master (pipeline) drives operands and OutReady; the slave (ALU) returns results.
`timescale 1ns/1ps
interface ex_alu_seq_if #(
  parameter int WIDTH = 32
);
  logic             Flush;
  logic             InValid;
  logic             InReady;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [4:0]       ALUControl;
  logic             OutValid;
  logic             OutReady;
  logic [WIDTH-1:0] ALUResult;
  logic [4:0]       RFlags;
  logic             Busy;

  modport master (
    output Flush, InValid, A, B, ALUControl, OutReady,
    input  InReady, OutValid, ALUResult, RFlags, Busy
  );

  modport slave (
    input  Flush, InValid, A, B, ALUControl, OutReady,
    output InReady, OutValid, ALUResult, RFlags, Busy
  );
endinterface

// File: rtl/ex_alu_seq.sv
// Multi-cycle EX ALU: single-cycle ops land 1 cycle after accept, MULT/DIV after WIDTH+1.
// Result holds while OutReady=0; InReady drops during MUL/DIV and while a result is unconsumed.
`timescale 1ns/1ps
module ex_alu_seq #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input logic         clk,
  input logic         rst_n,
  ex_alu_seq_if.slave io
);

  localparam logic [4:0] OP_ADD = 5'b00110;
  localparam logic [4:0] OP_SUB = 5'b00111;
  localparam logic [4:0] OP_MUL = 5'b01000;
  localparam logic [4:0] OP_DIV = 5'b01001;
  localparam logic [4:0] OP_AND = 5'b01010;
  localparam logic [4:0] OP_OR  = 5'b01011;
  localparam logic [4:0] OP_SHL = 5'b01100;
  localparam logic [4:0] OP_SHR = 5'b01101;
  localparam logic [4:0] OP_CMP = 5'b01110;
  localparam logic [4:0] OP_NOT = 5'b01111;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t             state;
  state_t             sc_next;
  logic [SHW-1:0]     cnt;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   sc_res;
  logic [4:0]         sc_flg;
  logic [WIDTH-1:0]   add_r;
  logic [WIDTH-1:0]   sub_r;
  logic               shift_big;
  logic               accept;
  logic               last;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_nxt;
  logic [WIDTH:0]     div_sh;
  logic               div_ge;
  logic [WIDTH-1:0]   div_sub;
  logic [2*WIDTH-1:0] div_nxt;

  assign io.InReady = (state == IDLE) | ((state == DONE) & io.OutReady);
  assign accept     = io.InValid & io.InReady;
  assign last       = (cnt == SHW'(WIDTH - 1));
  assign add_r      = io.A + io.B;
  assign sub_r      = io.A - io.B;
  assign shift_big  = |io.B[WIDTH-1:SHW];

  // Shift-add: acc = {partial product, remaining multiplier bits}
  assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, a_q} : '0);
  assign mul_nxt = {mul_sum, acc[WIDTH-1:1]};

  // Restoring divide: acc = {remainder, dividend bits shifting into quotient}
  assign div_sh  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign div_ge  = (div_sh >= {1'b0, b_q});
  assign div_sub = div_sh[WIDTH-1:0] - b_q;
  assign div_nxt = {(div_ge ? div_sub : div_sh[WIDTH-1:0]), acc[WIDTH-2:0], div_ge};

  always_comb begin
    sc_res  = '0;
    sc_flg  = '0;
    sc_next = DONE;
    case (io.ALUControl)
      OP_ADD: begin
        sc_res    = add_r;
        sc_flg[4] = (io.A[WIDTH-1] == io.B[WIDTH-1]) && (add_r[WIDTH-1] != io.A[WIDTH-1]);
      end
      OP_SUB: begin
        sc_res    = sub_r;
        sc_flg[4] = (io.A[WIDTH-1] != io.B[WIDTH-1]) && (sub_r[WIDTH-1] != io.A[WIDTH-1]);
        sc_flg[3] = io.A < io.B;
        sc_flg[2] = io.A > io.B;
        sc_flg[1] = io.A < io.B;
      end
      OP_MUL: sc_next = MUL;
      OP_DIV: begin
        if (io.B == '0) sc_flg[0] = 1'b1;
        else            sc_next   = DIV;
      end
      OP_AND: sc_res = io.A & io.B;
      OP_OR:  sc_res = io.A | io.B;
      OP_NOT: sc_res = ~io.A;
      OP_SHL: sc_res = shift_big ? '0 : (io.A << io.B[SHW-1:0]);
      OP_SHR: sc_res = shift_big ? '0 : (io.A >> io.B[SHW-1:0]);
      OP_CMP: begin
        sc_res    = {{(WIDTH-1){1'b0}}, io.A == io.B};
        sc_flg[2] = io.A > io.B;
        sc_flg[1] = io.A < io.B;
      end
      default: sc_flg[0] = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      io.OutValid  <= 1'b0;
      io.ALUResult <= '0;
      io.RFlags    <= '0;
      io.Busy      <= 1'b0;
      cnt          <= '0;
      a_q          <= '0;
      b_q          <= '0;
      acc          <= '0;
    end else if (io.Flush) begin
      // Result registers deliberately keep their last value
      state       <= IDLE;
      io.OutValid <= 1'b0;
      io.Busy     <= 1'b0;
      cnt         <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            a_q <= io.A;
            b_q <= io.B;
            cnt <= '0;
            case (sc_next)
              MUL: begin
                state       <= MUL;
                io.Busy     <= 1'b1;
                io.OutValid <= 1'b0;
                acc         <= {{WIDTH{1'b0}}, io.B};
              end
              DIV: begin
                state       <= DIV;
                io.Busy     <= 1'b1;
                io.OutValid <= 1'b0;
                acc         <= {{WIDTH{1'b0}}, io.A};
              end
              default: begin
                state        <= DONE;
                io.OutValid  <= 1'b1;
                io.ALUResult <= sc_res;
                io.RFlags    <= sc_flg;
              end
            endcase
          end else if ((state == DONE) && io.OutReady) begin
            state       <= IDLE;
            io.OutValid <= 1'b0;
          end
        end
        MUL: begin
          acc <= mul_nxt;
          cnt <= cnt + SHW'(1);
          if (last) begin
            state        <= DONE;
            io.Busy      <= 1'b0;
            io.OutValid  <= 1'b1;
            io.ALUResult <= mul_nxt[WIDTH-1:0];
            io.RFlags    <= {|mul_nxt[2*WIDTH-1:WIDTH], 4'b0000};
            cnt          <= '0;
          end
        end
        DIV: begin
          acc <= div_nxt;
          cnt <= cnt + SHW'(1);
          if (last) begin
            state        <= DONE;
            io.Busy      <= 1'b0;
            io.OutValid  <= 1'b1;
            io.ALUResult <= div_nxt[WIDTH-1:0];
            io.RFlags    <= {1'b0, a_q < b_q, 3'b000};
            cnt          <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_alu_seq.sv
// Self-checking bench for ex_alu_seq: vector table through a result scoreboard,
// plus directed busy, back-pressure, flush and mid-op reset sequences.
`timescale 1ns/1ps
module tb_ex_alu_seq;
  localparam int W = 32;

  localparam logic [4:0] ADD = 5'b00110, SUB = 5'b00111, MULT = 5'b01000, DIVO = 5'b01001;
  localparam logic [4:0] ANDO = 5'b01010, ORO = 5'b01011, SHL = 5'b01100, SHR = 5'b01101;
  localparam logic [4:0] CMP = 5'b01110, NOTO = 5'b01111;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [4:0]   op;
    logic [W-1:0] res;
    logic [4:0]   flg;
    int           lat;
  } vec_t;

  typedef struct {
    logic [W-1:0] res;
    logic [4:0]   flg;
    int           cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ex_alu_seq_if #(.WIDTH(W)) bus();
  ex_alu_seq #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .io(bus));

  exp_t exp_q[$];
  vec_t vecs[22];
  int   compared = 0;
  int   mismatched = 0;
  int   cyc = 0;
  bit   mon_waiting = 1'b1;
  int   mon_first = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    compared++;
    mismatched++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Scoreboard consumer: compares on every output handshake
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && bus.OutValid) begin
        if (mon_waiting) begin
          mon_first   = cyc;
          mon_waiting = 1'b0;
        end
        if (bus.OutReady) begin
          if (exp_q.size() == 0) fail_now("unexpected result");
          else begin
            e = exp_q.pop_front();
            chk("result", 64'(bus.ALUResult), 64'(e.res));
            chk("flags", 64'(bus.RFlags), 64'(e.flg));
            chk("latency", 64'(mon_first), 64'(e.cyc));
          end
          mon_waiting = 1'b1;
        end
      end
    end
  end

  task automatic issue_now(input logic [W-1:0] a, input logic [W-1:0] b, input logic [4:0] op,
                           input logic [W-1:0] res, input logic [4:0] flg, input int lat);
    int t = 0;
    exp_t e;
    bus.A = a;
    bus.B = b;
    bus.ALUControl = op;
    bus.InValid = 1'b1;
    #1;
    while (!bus.InReady && t < 200) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (!bus.InReady) fail_now("accept timeout");
    else begin
      e.res = res;
      e.flg = flg;
      e.cyc = cyc + lat;
      exp_q.push_back(e);
    end
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [4:0] op,
                       input logic [W-1:0] res, input logic [4:0] flg, input int lat);
    @(negedge clk);
    issue_now(a, b, op, res, flg, lat);
  endtask

  task automatic idle();
    @(negedge clk);
    bus.InValid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) fail_now("drain timeout");
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    mismatched++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    int seen;
    bus.Flush = 1'b0;
    bus.InValid = 1'b0;
    bus.A = '0;
    bus.B = '0;
    bus.ALUControl = '0;
    bus.OutReady = 1'b1;

    vecs[0]  = '{32'h7FFFFFFF, 32'h1,        ADD,     32'h80000000, 5'b10000, 1};
    vecs[1]  = '{32'h3,        32'h5,        SUB,     32'hFFFFFFFE, 5'b01010, 1};
    vecs[2]  = '{32'h9,        32'h9,        CMP,     32'h1,        5'b00000, 1};
    vecs[3]  = '{32'h00010000, 32'h00010000, MULT,    32'h0,        5'b10000, 33};
    vecs[4]  = '{32'd12,       32'd13,       MULT,    32'd156,      5'b00000, 33};
    vecs[5]  = '{32'd100,      32'd7,        DIVO,    32'd14,       5'b00000, 33};
    vecs[6]  = '{32'd5,        32'd0,        DIVO,    32'd0,        5'b00001, 1};
    vecs[7]  = '{32'h1,        32'd40,       SHL,     32'h0,        5'b00000, 1};
    vecs[8]  = '{32'h80000000, 32'd31,       SHR,     32'h1,        5'b00000, 1};
    vecs[9]  = '{32'h1,        32'h2,        5'b10101, 32'h0,       5'b00001, 1};
    vecs[10] = '{32'hF0F0F0F0, 32'h0FF00FF0, ANDO,    32'h00F000F0, 5'b00000, 1};
    vecs[11] = '{32'hF0F0F0F0, 32'h0FF00FF0, ORO,     32'hFFF0FFF0, 5'b00000, 1};
    vecs[12] = '{32'h12345678, 32'h0,        NOTO,    32'hEDCBA987, 5'b00000, 1};
    vecs[13] = '{32'd5,        32'd3,        SUB,     32'd2,        5'b00100, 1};
    vecs[14] = '{32'h80000000, 32'h1,        SUB,     32'h7FFFFFFF, 5'b10100, 1};
    vecs[15] = '{32'd3,        32'd10,       DIVO,    32'd0,        5'b01000, 33};
    vecs[16] = '{32'd3,        32'd9,        CMP,     32'd0,        5'b00010, 1};
    vecs[17] = '{32'h5,        32'h6,        5'b00000, 32'h0,       5'b00001, 1};
    vecs[18] = '{32'h3,        32'd4,        SHL,     32'h30,       5'b00000, 1};
    vecs[19] = '{32'hFFFFFFFF, 32'h1,        ADD,     32'h0,        5'b00000, 1};
    vecs[20] = '{32'hFFFFFFFF, 32'h2,        MULT,    32'hFFFFFFFE, 5'b10000, 33};
    vecs[21] = '{32'hFFFFFFFF, 32'h1,        DIVO,    32'hFFFFFFFF, 5'b00000, 33};

    // Reset values
    repeat (2) @(negedge clk);
    #1;
    chk("reset OutValid", 64'(bus.OutValid), 64'd0);
    chk("reset ALUResult", 64'(bus.ALUResult), 64'd0);
    chk("reset RFlags", 64'(bus.RFlags), 64'd0);
    chk("reset Busy", 64'(bus.Busy), 64'd0);
    chk("reset InReady", 64'(bus.InReady), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Table, issued back-to-back
    foreach (vecs[i]) issue(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].res, vecs[i].flg, vecs[i].lat);
    idle();
    drain();

    // Busy and InReady through a full multiply
    issue(32'd7, 32'd6, MULT, 32'd42, 5'b00000, 33);
    idle();
    #1;
    bad = (bus.Busy && !bus.InReady) ? 0 : 1;
    for (int i = 1; i < 32; i++) begin
      @(negedge clk);
      #1;
      if (!(bus.Busy && !bus.InReady)) bad++;
    end
    chk("mult busy cycles", 64'(bad), 64'd0);
    @(negedge clk);
    #1;
    chk("mult busy cleared", 64'(bus.Busy), 64'd0);
    chk("mult done valid", 64'(bus.OutValid), 64'd1);
    drain();

    // Back-pressure hold, then simultaneous consume+accept
    bus.OutReady = 1'b0;
    issue(32'hFF00FF00, 32'h0FF00FF0, ANDO, 32'h0F000F00, 5'b00000, 1);
    idle();
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      if (bus.ALUResult !== 32'h0F000F00 || !bus.OutValid || bus.InReady) bad++;
    end
    chk("backpressure hold", 64'(bad), 64'd0);
    @(negedge clk);
    bus.OutReady = 1'b1;
    issue_now(32'hFF00FF00, 32'h0FF00FF0, ORO, 32'hFFF0FFF0, 5'b00000, 1);
    idle();
    #1;
    chk("no-bubble OR valid", 64'(bus.OutValid), 64'd1);
    chk("no-bubble OR result", 64'(bus.ALUResult), 64'hFFF0FFF0);
    drain();

    // Flush in the middle of a divide
    issue(32'd1, 32'd2, ADD, 32'd3, 5'b00000, 1);
    idle();
    drain();
    issue(32'd100, 32'd7, DIVO, 32'd14, 5'b00000, 33);
    idle();
    repeat (8) @(negedge clk);
    @(negedge clk);
    bus.Flush = 1'b1;
    @(negedge clk);
    bus.Flush = 1'b0;
    exp_q.delete();
    mon_waiting = 1'b1;
    #1;
    chk("flush Busy", 64'(bus.Busy), 64'd0);
    chk("flush OutValid", 64'(bus.OutValid), 64'd0);
    chk("flush InReady", 64'(bus.InReady), 64'd1);
    chk("flush keeps ALUResult", 64'(bus.ALUResult), 64'd3);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      #1;
      if (bus.OutValid) seen = 1;
    end
    chk("no result after flush", 64'(seen), 64'd0);

    // Accept in the flush cycle is discarded
    @(negedge clk);
    bus.Flush = 1'b1;
    bus.A = 32'd7;
    bus.B = 32'd7;
    bus.ALUControl = ADD;
    bus.InValid = 1'b1;
    @(negedge clk);
    bus.Flush = 1'b0;
    bus.InValid = 1'b0;
    #1;
    chk("flushed accept dropped", 64'(bus.OutValid), 64'd0);
    chk("flushed accept no result", 64'(bus.ALUResult), 64'd3);

    // Flush discards a pending, unconsumed result
    bus.OutReady = 1'b0;
    issue(32'd20, 32'd22, ADD, 32'd42, 5'b00000, 1);
    idle();
    bus.Flush = 1'b1;
    @(negedge clk);
    bus.Flush = 1'b0;
    exp_q.delete();
    mon_waiting = 1'b1;
    bus.OutReady = 1'b1;
    #1;
    chk("flush pending result", 64'(bus.OutValid), 64'd0);

    // Asynchronous reset in the middle of a multiply
    issue(32'd12, 32'd13, MULT, 32'd156, 5'b00000, 33);
    idle();
    repeat (5) @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async rst OutValid", 64'(bus.OutValid), 64'd0);
    chk("async rst ALUResult", 64'(bus.ALUResult), 64'd0);
    chk("async rst RFlags", 64'(bus.RFlags), 64'd0);
    chk("async rst Busy", 64'(bus.Busy), 64'd0);
    exp_q.delete();
    mon_waiting = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    issue(32'd2, 32'd3, ADD, 32'd5, 5'b00000, 1);
    idle();
    drain();

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
